// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer that owns a 4 x 4-bit register file and
// drives one shared external combinational ALU.
//
// Commands arrive over a valid/ready handshake and are either immediate loads
// or register-to-register ALU operations. An ALU command presents registered
// operands/opcode for one EXEC cycle, captures the ALU result, then spends one
// WB cycle strobing the result before writing the low nibble to the
// destination register and the high nibble to HI.
//
// Ports:
//   iCLK, iRST          clock, asynchronous active-high reset
//   iCMD_VALID/READY    command handshake (ready only while idle)
//   iCMD_LOAD           1 = immediate load, 0 = ALU operation
//   iCMD_INST           ALU opcode
//   iCMD_SRCA/SRCB/DST  register indices
//   iCMD_IMM            immediate value for loads
//   oALU_A/B/INST       registered operands and opcode to the ALU
//   iALU_RESULT         combinational ALU result
//   oRES_VALID/DATA/DST completion strobe, result and destination
//   oERR                divide/mod-by-zero flag, qualified by oRES_VALID
//   oHI                 high nibble of the last ALU result
//   iRD_ADDR/oRD_DATA   combinational debug read of the register file
module alu_seq_ctrl #(
  parameter logic [7:0] DIVZ_VAL = 8'hFF,
  parameter logic [3:0] RST_VAL  = 4'h0
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iCMD_VALID,
  output logic       oCMD_READY,
  input  logic       iCMD_LOAD,
  input  logic [3:0] iCMD_INST,
  input  logic [1:0] iCMD_SRCA,
  input  logic [1:0] iCMD_SRCB,
  input  logic [1:0] iCMD_DST,
  input  logic [3:0] iCMD_IMM,
  output logic [3:0] oALU_A,
  output logic [3:0] oALU_B,
  output logic [3:0] oALU_INST,
  input  logic [7:0] iALU_RESULT,
  output logic       oRES_VALID,
  output logic [7:0] oRES_DATA,
  output logic [1:0] oRES_DST,
  output logic       oERR,
  output logic [3:0] oHI,
  input  logic [1:0] iRD_ADDR,
  output logic [3:0] oRD_DATA
);

  localparam int unsigned DW   = 4;
  localparam int unsigned RW   = 8;
  localparam int unsigned AW   = 2;
  localparam int unsigned NREG = 4;

  localparam logic [DW-1:0] OP_DIV = 4'h3;
  localparam logic [DW-1:0] OP_MOD = 4'h4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            accept;
  logic            divz;

  logic [DW-1:0]   regs [NREG];
  logic [DW-1:0]   hi_q;
  logic [DW-1:0]   alu_a_q;
  logic [DW-1:0]   alu_b_q;
  logic [DW-1:0]   alu_inst_q;
  logic            ready_q;
  logic            res_valid_q;
  logic [RW-1:0]   res_data_q;
  logic [AW-1:0]   res_dst_q;
  logic            err_q;
  logic            load_q;

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and accept decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iCMD_VALID) begin
          accept  = 1'b1;
          state_d = iCMD_LOAD ? WB : EXEC;
        end
      end
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DIV/MOD by zero is judged on the operands actually presented to the ALU
  assign divz = ((alu_inst_q == OP_DIV) || (alu_inst_q == OP_MOD)) && (alu_b_q == '0);

  // Datapath: operand issue, result capture, writeback
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= RST_VAL;
      end
      hi_q        <= RST_VAL;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_inst_q  <= '0;
      ready_q     <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_dst_q   <= '0;
      err_q       <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      // Ready and strobe track the state being entered so both are registered
      ready_q     <= (state_d == IDLE);
      res_valid_q <= (state_d == WB);

      if (accept) begin
        res_dst_q <= iCMD_DST;
        load_q    <= iCMD_LOAD;
        err_q     <= 1'b0;
        if (iCMD_LOAD) begin
          res_data_q <= {(RW - DW)'(0), iCMD_IMM};
        end else begin
          alu_a_q    <= regs[iCMD_SRCA];
          alu_b_q    <= regs[iCMD_SRCB];
          alu_inst_q <= iCMD_INST;
        end
      end

      if (state_q == EXEC) begin
        if (divz) begin
          res_data_q <= DIVZ_VAL;
          err_q      <= 1'b1;
        end else begin
          res_data_q <= iALU_RESULT;
          err_q      <= 1'b0;
        end
      end

      // Writeback on the WB exit edge; loads leave HI untouched
      if (state_q == WB) begin
        regs[res_dst_q] <= res_data_q[DW-1:0];
        if (!load_q) begin
          hi_q <= res_data_q[RW-1:DW];
        end
      end
    end
  end

  assign oCMD_READY = ready_q;
  assign oALU_A     = alu_a_q;
  assign oALU_B     = alu_b_q;
  assign oALU_INST  = alu_inst_q;
  assign oRES_VALID = res_valid_q;
  assign oRES_DATA  = res_data_q;
  assign oRES_DST   = res_dst_q;
  assign oERR       = err_q;
  assign oHI        = hi_q;
  assign oRD_DATA   = regs[iRD_ADDR];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl with a behavioural ALU
// attached to the ALU port and hand-computed expected results.
module tb_alu_seq_ctrl;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iCMD_VALID;
  logic       oCMD_READY;
  logic       iCMD_LOAD;
  logic [3:0] iCMD_INST;
  logic [1:0] iCMD_SRCA;
  logic [1:0] iCMD_SRCB;
  logic [1:0] iCMD_DST;
  logic [3:0] iCMD_IMM;
  logic [3:0] oALU_A;
  logic [3:0] oALU_B;
  logic [3:0] oALU_INST;
  logic [7:0] iALU_RESULT;
  logic       oRES_VALID;
  logic [7:0] oRES_DATA;
  logic [1:0] oRES_DST;
  logic       oERR;
  logic [3:0] oHI;
  logic [1:0] iRD_ADDR;
  logic [3:0] oRD_DATA;

  alu_seq_ctrl dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iCMD_VALID  (iCMD_VALID),
    .oCMD_READY  (oCMD_READY),
    .iCMD_LOAD   (iCMD_LOAD),
    .iCMD_INST   (iCMD_INST),
    .iCMD_SRCA   (iCMD_SRCA),
    .iCMD_SRCB   (iCMD_SRCB),
    .iCMD_DST    (iCMD_DST),
    .iCMD_IMM    (iCMD_IMM),
    .oALU_A      (oALU_A),
    .oALU_B      (oALU_B),
    .oALU_INST   (oALU_INST),
    .iALU_RESULT (iALU_RESULT),
    .oRES_VALID  (oRES_VALID),
    .oRES_DATA   (oRES_DATA),
    .oRES_DST    (oRES_DST),
    .oERR        (oERR),
    .oHI         (oHI),
    .iRD_ADDR    (iRD_ADDR),
    .oRD_DATA    (oRD_DATA)
  );

  always #5 iCLK = ~iCLK;

  // Behavioural ALU; divide/mod by zero returns 0 so the DUT substitution shows
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = {4'h0, a};
    eb = {4'h0, b};
    case (op)
      4'h0: return ea + eb;
      4'h1: return ea - eb;
      4'h2: return ea * eb;
      4'h3: return (b == 4'h0) ? 8'h00 : ea / eb;
      4'h4: return (b == 4'h0) ? 8'h00 : ea % eb;
      4'h5: return {4'h0, a & b};
      4'h6: return {4'h0, a | b};
      4'h7: return {4'h0, a ^ b};
      4'h8: return {4'h0, ~a};
      4'h9: return ea << b;
      4'ha: return ea >> b;
      4'hb: return {4'h0, ~(a & b)};
      4'hc: return {4'h0, ~(a | b)};
      4'hd: return {4'h0, ~(a ^ b)};
      4'he: return ea;
      default: return eb;
    endcase
  endfunction

  assign iALU_RESULT = alu_model(oALU_INST, oALU_A, oALU_B);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [1:0] dst;
    logic       err;
  } strobe_t;

  int      cyc = 0;
  int      acc_q[$];
  strobe_t st_q[$];
  logic [3:0] hi_exp;

  // Edge counter plus accept log, sampled at the active edge before NBA updates
  always @(posedge iCLK) begin
    cyc = cyc + 1;
    if (!iRST && iCMD_VALID && oCMD_READY) acc_q.push_back(cyc);
  end

  always @(negedge iCLK) begin
    if (oRES_VALID) st_q.push_back('{cyc, oRES_DATA, oRES_DST, oERR});
  end

  // Present a command and leave iCMD_VALID high; returns #1 after the accept edge
  task automatic send(input logic ld, input logic [3:0] inst, input logic [1:0] sa,
                      input logic [1:0] sb, input logic [1:0] d, input logic [3:0] imm);
    int n;
    iCMD_LOAD  = ld;
    iCMD_INST  = inst;
    iCMD_SRCA  = sa;
    iCMD_SRCB  = sb;
    iCMD_DST   = d;
    iCMD_IMM   = imm;
    iCMD_VALID = 1'b1;
    n = acc_q.size();
    for (int i = 0; i < 20 && acc_q.size() == n; i++) begin
      @(posedge iCLK);
      #1;
    end
    if (acc_q.size() == n) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_strobes(input int target, output logic ok);
    for (int i = 0; i < 20 && st_q.size() < target; i++) begin
      @(negedge iCLK);
      #1;
    end
    ok = (st_q.size() >= target);
    if (!ok) check("strobe_timeout", 32'(st_q.size()), 32'(target));
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [3:0] exp);
    iRD_ADDR = a;
    #1;
    check(tag, 32'(oRD_DATA), 32'(exp));
  endtask

  // One complete command: handshake, operand, strobe, latency and writeback checks
  task automatic run(input string tag, input logic ld, input logic [3:0] inst,
                     input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] d,
                     input logic [3:0] imm, input logic [3:0] ea, input logic [3:0] eb,
                     input logic [7:0] exp_data, input logic exp_err);
    int      ns;
    logic    ok;
    strobe_t s;
    ns = st_q.size();
    send(ld, inst, sa, sb, d, imm);
    iCMD_VALID = 1'b0;
    if (!ld) begin
      check({tag, "_alu_inst"}, 32'(oALU_INST), 32'(inst));
      check({tag, "_alu_a"}, 32'(oALU_A), 32'(ea));
      check({tag, "_alu_b"}, 32'(oALU_B), 32'(eb));
    end
    wait_strobes(ns + 1, ok);
    if (ok) begin
      s = st_q[ns];
      check({tag, "_data"}, 32'(s.data), 32'(exp_data));
      check({tag, "_dst"}, 32'(s.dst), 32'(d));
      check({tag, "_err"}, 32'(s.err), 32'(exp_err));
      check({tag, "_latency"}, 32'(s.cyc + 1 - acc_q[$]), ld ? 32'd1 : 32'd2);
      @(negedge iCLK);
      if (!ld) hi_exp = exp_data[7:4];
      rd_check({tag, "_wb"}, d, exp_data[3:0]);
      check({tag, "_hi"}, 32'(oHI), 32'(hi_exp));
    end
  endtask

  logic [7:0] sweep_exp [16] = '{8'h0D, 8'h07, 8'h1E, 8'h03, 8'h01, 8'h02, 8'h0B, 8'h09,
                                 8'h05, 8'h50, 8'h01, 8'h0D, 8'h04, 8'h06, 8'h0A, 8'h03};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   na;
    int   ns;
    logic ok;

    iRST       = 1'b1;
    iCMD_VALID = 1'b0;
    iCMD_LOAD  = 1'b0;
    iCMD_INST  = '0;
    iCMD_SRCA  = '0;
    iCMD_SRCB  = '0;
    iCMD_DST   = '0;
    iCMD_IMM   = '0;
    iRD_ADDR   = '0;
    hi_exp     = 4'h0;
    repeat (2) @(negedge iCLK);

    // Reset state
    check("rst_ready", 32'(oCMD_READY), 32'd1);
    check("rst_valid", 32'(oRES_VALID), 32'd0);
    check("rst_data", 32'(oRES_DATA), 32'd0);
    check("rst_hi", 32'(oHI), 32'd0);
    check("rst_alu", {20'd0, oALU_INST, oALU_A, oALU_B}, 32'd0);
    for (int r = 0; r < 4; r++) rd_check("rst_reg", 2'(r), 4'h0);
    iRST = 1'b0;
    @(negedge iCLK);

    // Loads, ADD, MUL
    run("ld_r0", 1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'h9, 4'h0, 4'h0, 8'h09, 1'b0);
    run("ld_r1", 1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 4'h3, 4'h0, 4'h0, 8'h03, 1'b0);
    run("add",   1'b0, 4'h0, 2'd0, 2'd1, 2'd2, 4'h0, 4'h9, 4'h3, 8'h0C, 1'b0);
    run("mul",   1'b0, 4'h2, 2'd0, 2'd1, 2'd3, 4'h0, 4'h9, 4'h3, 8'h1B, 1'b0);

    // Divide by zero substitution, then a clean MOD
    run("ld_r1z", 1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    run("divz",   1'b0, 4'h3, 2'd0, 2'd1, 2'd2, 4'h0, 4'h9, 4'h0, 8'hFF, 1'b1);
    run("ld_r1b", 1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 4'h3, 4'h0, 4'h0, 8'h03, 1'b0);
    run("mod",    1'b0, 4'h4, 2'd0, 2'd1, 2'd2, 4'h0, 4'h9, 4'h3, 8'h00, 1'b0);

    // Valid held high across three commands: load r3=7, r2=r3-r1, r0=r0+r0
    na = acc_q.size();
    ns = st_q.size();
    send(1'b1, 4'h0, 2'd0, 2'd0, 2'd3, 4'h7);
    send(1'b0, 4'h1, 2'd3, 2'd1, 2'd2, 4'h0);
    send(1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 4'h0);
    iCMD_VALID = 1'b0;
    wait_strobes(ns + 3, ok);
    repeat (4) @(negedge iCLK);
    check("stream_accepts", 32'(acc_q.size() - na), 32'd3);
    check("stream_strobes", 32'(st_q.size() - ns), 32'd3);
    if (acc_q.size() - na >= 3) begin
      check("stream_gap_load", 32'(acc_q[na+1] - acc_q[na]), 32'd2);
      check("stream_gap_alu", 32'(acc_q[na+2] - acc_q[na+1]), 32'd3);
    end
    if (ok) begin
      check("stream0", {22'd0, st_q[ns].dst, st_q[ns].data}, {22'd0, 2'd3, 8'h07});
      check("stream1", {22'd0, st_q[ns+1].dst, st_q[ns+1].data}, {22'd0, 2'd2, 8'h04});
      check("stream2", {22'd0, st_q[ns+2].dst, st_q[ns+2].data}, {22'd0, 2'd0, 8'h12});
    end
    rd_check("stream_r0", 2'd0, 4'h2);
    rd_check("stream_r2", 2'd2, 4'h4);
    rd_check("stream_r3", 2'd3, 4'h7);
    check("stream_hi", 32'(oHI), 32'h1);

    // Reset during EXEC of r2 = r0 + r1 (would be 5)
    ns = st_q.size();
    send(1'b0, 4'h0, 2'd0, 2'd1, 2'd2, 4'h0);
    iCMD_VALID = 1'b0;
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    check("rst_mid_ready", 32'(oCMD_READY), 32'd1);
    repeat (3) @(negedge iCLK);
    check("rst_mid_nostrobe", 32'(st_q.size()), 32'(ns));
    for (int r = 0; r < 4; r++) rd_check("rst_mid_reg", 2'(r), 4'h0);
    check("rst_mid_hi", 32'(oHI), 32'd0);
    hi_exp = 4'h0;

    // Opcode sweep with A = 4'hA, B = 4'h3
    run("ld_ra", 1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'hA, 4'h0, 4'h0, 8'h0A, 1'b0);
    run("ld_rb", 1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 4'h3, 4'h0, 4'h0, 8'h03, 1'b0);
    for (int op = 0; op < 16; op++) begin
      run($sformatf("op%0h", op), 1'b0, 4'(op), 2'd0, 2'd1, 2'd2, 4'h0, 4'hA, 4'h3,
          sweep_exp[op], 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
